// File: rtl/click_arbiter_if.sv
// rtl/click_arbiter_if.sv - handshake and status bundle between button front end and game core
interface click_arbiter_if #(
  parameter int N  = 4,
  parameter int CW = 4
);
  logic          start;
  logic [CW-1:0] max_clicks;
  logic [N-1:0]  click;
  logic          done;
  logic          step_valid;
  logic [1:0]    step_player;
  logic          step_ready;
  logic          active;
  logic [N-1:0]  exhausted;
  logic [1:0]    state;

  modport slave (
    input  start, max_clicks, click, done, step_ready,
    output step_valid, step_player, active, exhausted, state
  );

  modport master (
    output start, max_clicks, click, done, step_ready,
    input  step_valid, step_player, active, exhausted, state
  );
endinterface

// File: rtl/click_arbiter.sv
// rtl/click_arbiter.sv - round-robin click arbiter with per-player budget
module click_arbiter (
  input  logic            clk,
  input  logic            rst,
  click_arbiter_if.slave  bus
);
  localparam int N  = 4;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          step_valid_q, step_valid_d;
  logic [1:0]    step_player_q, step_player_d;
  logic          active_q;
  logic [N-1:0]  exhausted_q, exhausted_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  prev_q;
  logic [CW-1:0] budget_q, budget_d;
  logic [CW-1:0] used_q [N];
  logic [CW-1:0] used_d [N];
  logic [1:0]    ptr_q, ptr_d;

  logic          accept, free, found;
  logic [N-1:0]  acc_oh, load_oh, rise, pend_eff;
  logic [1:0]    base, pick, idx;
  logic [CW-1:0] used_inc;

  always_comb begin
    state_d       = state_q;
    step_valid_d  = step_valid_q;
    step_player_d = step_player_q;
    exhausted_d   = exhausted_q;
    pending_d     = pending_q;
    budget_d      = budget_q;
    used_d        = used_q;
    ptr_d         = ptr_q;

    accept   = step_valid_q & bus.step_ready;
    free     = ~step_valid_q | accept;
    acc_oh   = accept ? (N'(1) << step_player_q) : '0;
    rise     = bus.click & ~prev_q;
    pend_eff = pending_q & ~acc_oh;
    load_oh  = '0;
    used_inc = used_q[step_player_q] + CW'(1);

    // Search starts just past the player being accepted so the pointer update takes effect immediately
    base  = accept ? step_player_q + 2'd1 : ptr_q;
    found = 1'b0;
    pick  = base;
    idx   = base;
    for (int k = 0; k < N; k++) begin
      idx = base + 2'(k);
      if (!found && pend_eff[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    case (state_q)
      S_RUN: begin
        if (accept) begin
          used_d[step_player_q] = used_inc;
          ptr_d                 = step_player_q + 2'd1;
          if (used_inc == budget_q) exhausted_d[step_player_q] = 1'b1;
        end
        if (bus.done) begin
          state_d      = S_HALT;
          step_valid_d = 1'b0;
          pending_d    = '0;
        end else if (&exhausted_q && !step_valid_q) begin
          state_d   = S_HALT;
          pending_d = '0;
        end else begin
          if (free) begin
            step_valid_d = found;
            if (found) begin
              step_player_d = pick;
              load_oh       = N'(1) << pick;
            end
          end
          pending_d = ((pending_q & ~load_oh) | rise) & ~exhausted_d;
        end
      end
      default: begin
        if (bus.start) begin
          state_d      = S_RUN;
          step_valid_d = 1'b0;
          budget_d     = bus.max_clicks;
          pending_d    = '0;
          ptr_d        = '0;
          exhausted_d  = {N{bus.max_clicks == '0}};
          for (int i = 0; i < N; i++) used_d[i] = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      step_valid_q  <= 1'b0;
      step_player_q <= '0;
      active_q      <= 1'b0;
      exhausted_q   <= '0;
      pending_q     <= '0;
      prev_q        <= '0;
      budget_q      <= '0;
      ptr_q         <= '0;
      for (int i = 0; i < N; i++) used_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      step_valid_q  <= step_valid_d;
      step_player_q <= step_player_d;
      active_q      <= (state_d == S_RUN);
      exhausted_q   <= exhausted_d;
      pending_q     <= pending_d;
      prev_q        <= bus.click;
      budget_q      <= budget_d;
      ptr_q         <= ptr_d;
      used_q        <= used_d;
    end
  end

  assign bus.step_valid  = step_valid_q;
  assign bus.step_player = step_player_q;
  assign bus.active      = active_q;
  assign bus.exhausted   = exhausted_q;
  assign bus.state       = state_q;
endmodule
